// File: rtl/thread_regfile.sv
// thread_regfile
//   Register file for one SIMT thread lane. It holds sixteen DATA_BITS-wide
//   registers. R0-R12 are general purpose. R13 mirrors block_id. R14 and
//   R15 hold THREADS_PER_BLOCK and THREAD_ID as constants. Operands are
//   captured into rs/rt while the core is in REQUEST. Results are written
//   back while the core is in UPDATE.
//
// Ports
//   clk                       rising-edge clock
//   reset                     asynchronous active-low reset
//   enable                    lane active; when low every register and output holds
//   block_id[7:0]             current block index, zero-extended into R13 every enabled cycle
//   core_state[2:0]           scheduler state (REQUEST=011, UPDATE=110 are the ones acted on)
//   decoded_rd_address[3:0]   destination register
//   decoded_rs_address[3:0]   source register 1
//   decoded_rt_address[3:0]   source register 2
//   decoded_reg_write_enable  instruction writes rd
//   decoded_reg_input_mux[1:0] writeback source: 00 ALU, 01 LSU, 10 immediate, 11 none
//   decoded_immediate[7:0]    immediate, zero-extended on write
//   alu_out, lsu_out          writeback data
//   rs, rt                    registered operands
module thread_regfile #(
    parameter int DATA_BITS         = 16,
    parameter int THREADS_PER_BLOCK = 4,
    parameter int THREAD_ID         = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [7:0]           block_id,
    input  logic [2:0]           core_state,
    input  logic [3:0]           decoded_rd_address,
    input  logic [3:0]           decoded_rs_address,
    input  logic [3:0]           decoded_rt_address,
    input  logic                 decoded_reg_write_enable,
    input  logic [1:0]           decoded_reg_input_mux,
    input  logic [7:0]           decoded_immediate,
    input  logic [DATA_BITS-1:0] alu_out,
    input  logic [DATA_BITS-1:0] lsu_out,
    output logic [DATA_BITS-1:0] rs,
    output logic [DATA_BITS-1:0] rt
);

    localparam logic [2:0] STATE_REQUEST = 3'b011;
    localparam logic [2:0] STATE_UPDATE  = 3'b110;

    localparam logic [DATA_BITS-1:0] BLOCK_DIM  = DATA_BITS'(THREADS_PER_BLOCK);
    localparam logic [DATA_BITS-1:0] THREAD_IDX = DATA_BITS'(THREAD_ID);

    // Index of the first special register; R13..R15 are read-only to software.
    localparam logic [3:0] FIRST_SPECIAL = 4'd13;

    logic [DATA_BITS-1:0] regs [16];
    logic [DATA_BITS-1:0] wb_data;
    logic                 wb_valid;
    logic                 wr_en;
    logic [DATA_BITS-1:0] block_ext;

    always_comb begin
        wb_data  = '0;
        wb_valid = 1'b0;
        case (decoded_reg_input_mux)
            2'b00: begin
                wb_data  = alu_out;
                wb_valid = 1'b1;
            end
            2'b01: begin
                wb_data  = lsu_out;
                wb_valid = 1'b1;
            end
            2'b10: begin
                wb_data[7:0] = decoded_immediate;
                wb_valid     = 1'b1;
            end
            default: begin
                wb_valid = 1'b0;
            end
        endcase
    end

    always_comb begin
        block_ext      = '0;
        block_ext[7:0] = block_id;
    end

    assign wr_en = (core_state == STATE_UPDATE) && decoded_reg_write_enable
                   && wb_valid && (decoded_rd_address < FIRST_SPECIAL);

    // R14/R15 are only ever loaded by reset, so they behave as constants.
    // REQUEST and UPDATE never coincide, so reads need no bypass from the
    // write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 13; i++) begin
                regs[i] <= '0;
            end
            regs[13] <= '0;
            regs[14] <= BLOCK_DIM;
            regs[15] <= THREAD_IDX;
            rs       <= '0;
            rt       <= '0;
        end else if (enable) begin
            regs[13] <= block_ext;
            if (core_state == STATE_REQUEST) begin
                rs <= regs[decoded_rs_address];
                rt <= regs[decoded_rt_address];
            end
            if (wr_en) begin
                regs[decoded_rd_address] <= wb_data;
            end
        end
    end

endmodule

// File: tb/tb_thread_regfile.sv
// tb_thread_regfile
//   Self-checking bench for thread_regfile (DATA_BITS=16, THREADS_PER_BLOCK=4,
//   THREAD_ID=2). A behavioural model of the register file is kept in arrays.
//   The model is advanced from the same stimulus that is applied to the DUT.
//   rs/rt are sampled 1 ns after each rising edge.
module tb_thread_regfile;

    localparam int DB = 16;
    localparam logic [2:0] S_IDLE    = 3'b000;
    localparam logic [2:0] S_FETCH   = 3'b001;
    localparam logic [2:0] S_DECODE  = 3'b010;
    localparam logic [2:0] S_REQUEST = 3'b011;
    localparam logic [2:0] S_WAIT    = 3'b100;
    localparam logic [2:0] S_EXECUTE = 3'b101;
    localparam logic [2:0] S_UPDATE  = 3'b110;
    localparam logic [2:0] S_DONE    = 3'b111;

    logic          clk;
    logic          reset;
    logic          enable;
    logic [7:0]    block_id;
    logic [2:0]    core_state;
    logic [3:0]    decoded_rd_address;
    logic [3:0]    decoded_rs_address;
    logic [3:0]    decoded_rt_address;
    logic          decoded_reg_write_enable;
    logic [1:0]    decoded_reg_input_mux;
    logic [7:0]    decoded_immediate;
    logic [DB-1:0] alu_out;
    logic [DB-1:0] lsu_out;
    logic [DB-1:0] rs;
    logic [DB-1:0] rt;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [DB-1:0] m_regs [16];
    logic [DB-1:0] m_rs;
    logic [DB-1:0] m_rt;

    thread_regfile #(
        .DATA_BITS        (DB),
        .THREADS_PER_BLOCK(4),
        .THREAD_ID        (2)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .enable                  (enable),
        .block_id                (block_id),
        .core_state              (core_state),
        .decoded_rd_address      (decoded_rd_address),
        .decoded_rs_address      (decoded_rs_address),
        .decoded_rt_address      (decoded_rt_address),
        .decoded_reg_write_enable(decoded_reg_write_enable),
        .decoded_reg_input_mux   (decoded_reg_input_mux),
        .decoded_immediate       (decoded_immediate),
        .alu_out                 (alu_out),
        .lsu_out                 (lsu_out),
        .rs                      (rs),
        .rt                      (rt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_regs[14] = 16'd4;
        m_regs[15] = 16'd2;
        m_rs = '0;
        m_rt = '0;
    endfunction

    // One enabled clock edge in plain terms: operands are read from the old
    // contents, a write lands only for rd 0..12 with a real source, and R13
    // takes block_id.
    function automatic void model_edge();
        logic [DB-1:0] old_rs_val;
        logic [DB-1:0] old_rt_val;
        int rd;
        if (!enable) return;
        old_rs_val = m_regs[int'(decoded_rs_address)];
        old_rt_val = m_regs[int'(decoded_rt_address)];
        rd = int'(decoded_rd_address);
        if (core_state == S_REQUEST) begin
            m_rs = old_rs_val;
            m_rt = old_rt_val;
        end
        if (core_state == S_UPDATE && decoded_reg_write_enable && rd <= 12) begin
            if (decoded_reg_input_mux == 2'd0) m_regs[rd] = alu_out;
            else if (decoded_reg_input_mux == 2'd1) m_regs[rd] = lsu_out;
            else if (decoded_reg_input_mux == 2'd2) m_regs[rd] = 16'(decoded_immediate);
        end
        m_regs[13] = 16'(block_id);
    endfunction

    task automatic step(input logic en, input logic [2:0] st);
        enable     = en;
        core_state = st;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [3:0] a, input logic [3:0] b);
        decoded_rs_address = a;
        decoded_rt_address = b;
        step(1'b1, S_REQUEST);
    endtask

    task automatic upd(input logic [3:0] rd, input logic [1:0] mux, input logic [7:0] imm,
                       input logic [DB-1:0] alu, input logic [DB-1:0] lsu);
        decoded_rd_address       = rd;
        decoded_reg_input_mux    = mux;
        decoded_immediate        = imm;
        alu_out                  = alu;
        lsu_out                  = lsu;
        decoded_reg_write_enable = 1'b1;
        step(1'b1, S_UPDATE);
        decoded_reg_write_enable = 1'b0;
        step(1'b1, S_DONE);
        step(1'b1, S_FETCH);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        tests_run++;
        if (rs !== 16'h0000 || rt !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_outputs: rs=%h rt=%h expected 0000 0000", rs, rt);
        end
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        req(4'd14, 4'd15);
        tests_run++;
        if (rs !== 16'h0004 || rt !== 16'h0002) begin
            tests_failed++;
            $display("FAIL reset_special: rs=%h rt=%h expected 0004 0002", rs, rt);
        end
        req(4'd0, 4'd12);
        tests_run++;
        if (rs !== 16'h0000 || rt !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_gpr: rs=%h rt=%h expected 0000 0000", rs, rt);
        end
    endtask

    task automatic test_immediate();
        upd(4'd1, 2'b10, 8'hA5, 16'hFFFF, 16'hFFFF);
        req(4'd1, 4'd0);
        tests_run++;
        if (rs !== 16'h00A5) begin
            tests_failed++;
            $display("FAIL imm_zero_ext: rs=%h expected 00a5", rs);
        end
    endtask

    task automatic test_alu_lsu();
        upd(4'd2, 2'b00, 8'h00, 16'h3C00, 16'h1111);
        upd(4'd3, 2'b01, 8'h00, 16'h2222, 16'hBEEF);
        req(4'd2, 4'd3);
        tests_run++;
        if (rs !== 16'h3C00 || rt !== 16'hBEEF) begin
            tests_failed++;
            $display("FAIL alu_lsu_wb: rs=%h rt=%h expected 3c00 beef", rs, rt);
        end
    endtask

    task automatic test_readonly();
        upd(4'd15, 2'b10, 8'h77, 16'h0, 16'h0);
        upd(4'd14, 2'b00, 8'h00, 16'hDEAD, 16'h0);
        upd(4'd13, 2'b01, 8'h00, 16'h0, 16'hCAFE);
        req(4'd15, 4'd14);
        tests_run++;
        if (rs !== 16'h0002 || rt !== 16'h0004) begin
            tests_failed++;
            $display("FAIL readonly_write: rs=%h rt=%h expected 0002 0004", rs, rt);
        end
        upd(4'd4, 2'b10, 8'h3D, 16'h0, 16'h0);
        upd(4'd4, 2'b11, 8'h99, 16'h5555, 16'h6666);
        req(4'd4, 4'd4);
        tests_run++;
        if (rs !== 16'h003D || rt !== 16'h003D) begin
            tests_failed++;
            $display("FAIL reserved_mux: rs=%h rt=%h expected 003d 003d", rs, rt);
        end
        block_id = 8'h09;
        step(1'b1, S_DECODE);
        req(4'd13, 4'd13);
        tests_run++;
        if (rs !== 16'h0009 || rt !== 16'h0009) begin
            tests_failed++;
            $display("FAIL block_id_r13: rs=%h rt=%h expected 0009 0009", rs, rt);
        end
        block_id = 8'hF3;
        step(1'b1, S_DECODE);
        req(4'd13, 4'd0);
        tests_run++;
        if (rs !== 16'h00F3) begin
            tests_failed++;
            $display("FAIL block_id_zext: rs=%h expected 00f3", rs);
        end
    endtask

    task automatic test_enable_gating();
        logic [DB-1:0] held_rs;
        logic [DB-1:0] held_rt;
        upd(4'd5, 2'b00, 8'h00, 16'h1234, 16'h0);
        req(4'd1, 4'd2);
        held_rs = rs;
        held_rt = rt;
        block_id = 8'h42;
        decoded_rs_address = 4'd5;
        decoded_rt_address = 4'd13;
        step(1'b0, S_REQUEST);
        tests_run++;
        if (rs !== held_rs || rt !== held_rt) begin
            tests_failed++;
            $display("FAIL enable_hold_req: rs=%h rt=%h expected %h %h", rs, rt, held_rs, held_rt);
        end
        decoded_rd_address       = 4'd5;
        decoded_reg_input_mux    = 2'b10;
        decoded_immediate        = 8'h55;
        decoded_reg_write_enable = 1'b1;
        step(1'b0, S_UPDATE);
        decoded_reg_write_enable = 1'b0;
        req(4'd5, 4'd13);
        tests_run++;
        if (rs !== 16'h1234 || rt !== 16'h00F3) begin
            tests_failed++;
            $display("FAIL enable_no_write: rs=%h rt=%h expected 1234 00f3", rs, rt);
        end
        block_id = 8'h09;
    endtask

    task automatic test_async_reset();
        upd(4'd6, 2'b10, 8'hFF, 16'h0, 16'h0);
        req(4'd6, 4'd15);
        tests_run++;
        if (rs !== 16'h00FF || rt !== 16'h0002) begin
            tests_failed++;
            $display("FAIL pre_reset_read: rs=%h rt=%h expected 00ff 0002", rs, rt);
        end
        step(1'b1, S_WAIT);
        #2;
        reset = 1'b0;
        #1;
        tests_run++;
        if (rs !== 16'h0000 || rt !== 16'h0000) begin
            tests_failed++;
            $display("FAIL async_reset: rs=%h rt=%h expected 0000 0000", rs, rt);
        end
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        req(4'd6, 4'd14);
        tests_run++;
        if (rs !== 16'h0000 || rt !== 16'h0004) begin
            tests_failed++;
            $display("FAIL post_reset_read: rs=%h rt=%h expected 0000 0004", rs, rt);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            block_id                 = 8'($urandom);
            decoded_rd_address       = 4'($urandom);
            decoded_rs_address       = 4'($urandom);
            decoded_rt_address       = 4'($urandom);
            decoded_reg_write_enable = 1'($urandom);
            decoded_reg_input_mux    = 2'($urandom);
            decoded_immediate        = 8'($urandom);
            alu_out                  = 16'($urandom);
            lsu_out                  = 16'($urandom);
            step(($urandom_range(0, 7) != 0), 3'($urandom));
            tests_run++;
            if (rs !== m_rs || rt !== m_rt) begin
                tests_failed++;
                $display("FAIL random_%0d: rs=%h rt=%h expected %h %h", n, rs, rt, m_rs, m_rt);
            end
        end
        // Sweep every register to expose any write that landed where it should not.
        for (int a = 0; a < 16; a++) begin
            req(4'(a), 4'(15 - a));
            tests_run++;
            if (rs !== m_rs || rt !== m_rt) begin
                tests_failed++;
                $display("FAIL sweep_r%0d: rs=%h rt=%h expected %h %h", a, rs, rt, m_rs, m_rt);
            end
        end
    endtask

    initial begin
        reset                    = 1'b0;
        enable                   = 1'b0;
        block_id                 = 8'h00;
        core_state               = S_IDLE;
        decoded_rd_address       = 4'd0;
        decoded_rs_address       = 4'd0;
        decoded_rt_address       = 4'd0;
        decoded_reg_write_enable = 1'b0;
        decoded_reg_input_mux    = 2'b00;
        decoded_immediate        = 8'h00;
        alu_out                  = '0;
        lsu_out                  = '0;
        model_reset();

        test_reset();
        test_immediate();
        test_alu_lsu();
        test_readonly();
        test_enable_gating();
        test_async_reset();
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
